vga_timing_gen: RTL

Parametrised VGA timing generator, successor to the fixed 640x480 sync block. Produces hsync/vsync/video_on for any mode set by parameters, with configurable sync polarity. Coordinates are issued early, and sync/blank are delayed by a parametrised pipeline, so frame-buffer read latency is absorbed. Sits between the pixel clock source and the frame-buffer/colour output stage.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_timing_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the timing-strobe bundle shared by the VGA blocks
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } timing_t;
  localparam timing_t TIMING_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, line_start: 1'b0, frame_start: 1'b0};
  function automatic timing_t timing_idle(input logic hs_pol, input logic vs_pol);
    return '{active: 1'b0, hsync: ~hs_pol, vsync: ~vs_pol, line_start: 1'b0, frame_start: 1'b0};
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with async reset to RESET_VAL; DEPTH=0 is a wire
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             VGA_CLK_IN,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = VGA_CLK_IN ^ reset;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] sr [DEPTH];
    // shift one stage per clock; reset flushes every stage to the idle value
    always_ff @(posedge VGA_CLK_IN or posedge reset)
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with early coordinates and delayed sync/blank/strobes
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          VGA_CLK_IN,
  input  logic          reset,
  input  logic          en,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count,
  output logic          VGA_CLK_OUT
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam timing_t IDLE = timing_idle(HS_POL, VS_POL);
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic h_last, v_last;
  timing_t raw, dly;
  assign h_last = h == H_LAST;
  assign v_last = v == V_LAST;
  // advance the raster; while disabled it parks at the frame origin and the frame tally holds
  always_ff @(posedge VGA_CLK_IN or posedge reset)
    if (reset) begin
      h <= '0;
      v <= '0;
      frame_count <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_last ? '0 : h + 1'b1;
      if (h_last) v <= v_last ? '0 : v + 1'b1;
      if (h_last && v_last) frame_count <= frame_count + 1'b1;
    end
  // decode the raster position; idle values whenever the raster is held so nothing leaks downstream
  always_comb
    raw = (en && !reset) ? timing_t'{
      active: h < H_ACT && v < V_ACT,
      hsync: (h >= HS_BEG && h < HS_END) ? HS_POL : ~HS_POL,
      vsync: (v >= VS_BEG && v < VS_END) ? VS_POL : ~VS_POL,
      line_start: h == '0,
      frame_start: h == '0 && v == '0
    } : IDLE;
  vga_delay_line #(.DEPTH(PIPE_DLY), .WIDTH($bits(timing_t)), .RESET_VAL(IDLE)) u_dly (
    .VGA_CLK_IN(VGA_CLK_IN),
    .reset(reset),
    .d(raw),
    .q(dly)
  );
  assign pixel_x = h;
  assign pixel_y = v;
  assign video_on = dly.active;
  assign hsync = dly.hsync;
  assign vsync = dly.vsync;
  assign line_start = dly.line_start;
  assign frame_start = dly.frame_start;
  assign VGA_CLK_OUT = VGA_CLK_IN;
endmodule
